freq_gear_ctrl: RTL and testbench

//  Parametrised frequency-gear controller and phase generator for the function generator.

---
 rtl/freq_gear_pkg.sv | 41 ++++
 rtl/freq_gear_ctrl_checker.sv | 29 ++
 rtl/freq_gear_ctrl_prescaler.sv | 42 ++++
 rtl/freq_gear_ctrl.sv | 148 ++++++++++++++
 tb/tb_freq_gear_ctrl.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/freq_gear_pkg.sv
// Shared definitions for the frequency-gear controller: default gear table,
// the 50 MHz / 40 us sample divider, default widths and the gear-to-step lookup.
package freq_gear_pkg;

    localparam int DIV_50M_40US = 2000;

    localparam int N_GEARS_DEF = 4;
    localparam int GEAR_W_DEF  = $clog2(N_GEARS_DEF);
    localparam int STEP_W_DEF  = 8;
    localparam int PHASE_W_DEF = 8;

    // Entry g is the phase step of gear g; gear 0 sits in the LSBs.
    localparam logic [N_GEARS_DEF*STEP_W_DEF-1:0] STEP_TABLE_DEF =
        {8'd20, 8'd10, 8'd2, 8'd1};

    typedef logic [GEAR_W_DEF-1:0]  gear_t;
    typedef logic [STEP_W_DEF-1:0]  step_t;
    typedef logic [PHASE_W_DEF-1:0] phase_t;

    // The lookup works on a zero-extended table so any parameter set fits.
    localparam int TABLE_MAX_W = 256;
    localparam int STEP_MAX_W  = 32;

    // Returns the step_w-bit entry of the packed table selected by gear.
    function automatic logic [STEP_MAX_W-1:0] step_lookup(
        input logic [TABLE_MAX_W-1:0] tbl,
        input int unsigned            gear,
        input int unsigned            step_w
    );
        logic [TABLE_MAX_W-1:0] shifted;
        logic [STEP_MAX_W-1:0]  mask;
        shifted = tbl >> (gear * step_w);
        if (step_w >= 32'd32) begin
            mask = '1;
        end else begin
            mask = (32'd1 << step_w) - 32'd1;
        end
        return STEP_MAX_W'(shifted) & mask;
    endfunction

endpackage

// File: rtl/freq_gear_ctrl_checker.sv
// Protocol checks for freq_gear_ctrl outputs.
module freq_gear_ctrl_checker #(
    parameter int N_GEARS = 4,
    parameter int GEAR_W  = 2,
    parameter int DIV     = 2000
) (
    input logic              clk,
    input logic              rst_n,
    input logic              en,
    input logic              sample_tick,
    input logic              wrap,
    input logic [GEAR_W-1:0] gear
);

    a_wrap_on_tick: assert property (@(posedge clk) disable iff (!rst_n)
        wrap |-> sample_tick);

    a_no_tick_when_idle: assert property (@(posedge clk) disable iff (!rst_n)
        !en |=> !sample_tick);

    a_gear_range: assert property (@(posedge clk) disable iff (!rst_n)
        32'(gear) < 32'(N_GEARS));

    if (DIV > 1) begin : g_tick_single
        a_tick_single: assert property (@(posedge clk) disable iff (!rst_n)
            sample_tick |=> !sample_tick);
    end

endmodule

// File: rtl/freq_gear_ctrl_prescaler.sv
// Sample-tick prescaler: counts 0..DIV-1 while enabled and flags the last
// count. The flag is combinational from the counter so the top level can
// register the tick, the phase and the wrap on the same clock edge.
module fgc_tick_prescaler #(
    parameter int DIV = 2000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear when disabled, roll over after the last count.
    always_comb begin
        tick  = 1'b0;
        cnt_d = cnt_q;
        if (!en) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            tick  = 1'b1;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/freq_gear_ctrl.sv
// Frequency-gear controller and phase generator.
// Holds the selected gear, maps it to a phase step, and advances the wavetable
// phase once per sample tick. Optional macro FGC_WRAP_SYNC_EN: a new step is
// committed only on a tick that wraps the phase, so output periods stay whole.
module freq_gear_ctrl
    import freq_gear_pkg::*;
#(
    parameter int N_GEARS = N_GEARS_DEF,
    parameter int GEAR_W  = $clog2(N_GEARS),
    parameter int STEP_W  = STEP_W_DEF,
    parameter int PHASE_W = PHASE_W_DEF,
    parameter int DIV     = DIV_50M_40US,
    parameter logic [N_GEARS*STEP_W-1:0] STEP_TABLE = STEP_TABLE_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               gear_up,
    input  logic               gear_dn,
    input  logic               gear_load,
    input  logic [GEAR_W-1:0]  gear_in,
    output logic [GEAR_W-1:0]  gear,
    output logic [STEP_W-1:0]  f_step,
    output logic               sample_tick,
    output logic [PHASE_W-1:0] phase,
    output logic               wrap
);

    localparam logic [GEAR_W-1:0] GEAR_MAX   = GEAR_W'(N_GEARS - 1);
    localparam logic [GEAR_W:0]   GEAR_LIMIT = (GEAR_W + 1)'(N_GEARS);
    localparam logic [STEP_W-1:0] RST_STEP   = STEP_TABLE[STEP_W-1:0];

    logic               tick_s;
    logic               commit_s;
    logic [STEP_W-1:0]  pending_step_s;
    logic [PHASE_W:0]   phase_sum_s;

    logic [GEAR_W-1:0]  gear_q, gear_d;
    logic [STEP_W-1:0]  f_step_q, f_step_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic               wrap_q, wrap_d;
    logic               sample_tick_q, sample_tick_d;

    fgc_tick_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .tick  (tick_s)
    );

    // Gear selection: load (clamped) beats up/down; up+down together holds.
    always_comb begin
        gear_d = gear_q;
        if (gear_load) begin
            if ({1'b0, gear_in} >= GEAR_LIMIT) begin
                gear_d = GEAR_MAX;
            end else begin
                gear_d = gear_in;
            end
        end else if (gear_up && !gear_dn) begin
            if (gear_q != GEAR_MAX) begin
                gear_d = gear_q + GEAR_W'(1);
            end else begin
                gear_d = gear_q;
            end
        end else if (gear_dn && !gear_up) begin
            if (gear_q != '0) begin
                gear_d = gear_q - GEAR_W'(1);
            end else begin
                gear_d = gear_q;
            end
        end else begin
            gear_d = gear_q;
        end
    end

    // Step the gear register currently asks for.
    always_comb begin
        pending_step_s = STEP_W'(step_lookup(TABLE_MAX_W'(STEP_TABLE),
                                             32'(gear_q), STEP_W));
    end

    // Phase advance with carry; the tick always uses the step already applied.
    always_comb begin
        phase_sum_s   = {1'b0, phase_q} + (PHASE_W + 1)'(f_step_q);
        sample_tick_d = tick_s;
        if (tick_s) begin
            phase_d = phase_sum_s[PHASE_W-1:0];
            wrap_d  = phase_sum_s[PHASE_W];
        end else begin
            phase_d = phase_q;
            wrap_d  = 1'b0;
        end
    end

    // Step commit: every tick, or only on a wrapping tick when whole periods are wanted.
    always_comb begin
`ifdef FGC_WRAP_SYNC_EN
        commit_s = tick_s && phase_sum_s[PHASE_W];
`else
        commit_s = tick_s;
`endif
        if (commit_s) begin
            f_step_d = pending_step_s;
        end else begin
            f_step_d = f_step_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gear_q        <= '0;
            f_step_q      <= RST_STEP;
            phase_q       <= '0;
            wrap_q        <= 1'b0;
            sample_tick_q <= 1'b0;
        end else begin
            gear_q        <= gear_d;
            f_step_q      <= f_step_d;
            phase_q       <= phase_d;
            wrap_q        <= wrap_d;
            sample_tick_q <= sample_tick_d;
        end
    end

    assign gear        = gear_q;
    assign f_step      = f_step_q;
    assign phase       = phase_q;
    assign wrap        = wrap_q;
    assign sample_tick = sample_tick_q;

    freq_gear_ctrl_checker #(
        .N_GEARS (N_GEARS),
        .GEAR_W  (GEAR_W),
        .DIV     (DIV)
    ) u_checker (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .sample_tick (sample_tick_q),
        .wrap        (wrap_q),
        .gear        (gear_q)
    );

endmodule

// File: tb/tb_freq_gear_ctrl.sv
// Testbench for freq_gear_ctrl: behavioural model plus literal expectations.
module tb_freq_gear_ctrl;

    localparam int TB_DIV = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, en, gear_up, gear_dn, gear_load;
    logic [1:0] gear_in;
    logic [1:0] gear;
    logic [7:0] f_step, phase;
    logic       sample_tick, wrap;

    logic       en_b, gear_up_b, gear_dn_b, gear_load_b;
    logic [1:0] gear_in_b;
    logic [1:0] gear_b;
    logic [7:0] f_step_b, phase_b;
    logic       sample_tick_b, wrap_b;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    int tbl [4] = '{1, 2, 10, 20};
    int m_gear, m_step, m_phase, m_elapsed;
    bit m_tick, m_wrap;

    freq_gear_ctrl #(.DIV(TB_DIV)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .gear_up(gear_up), .gear_dn(gear_dn),
        .gear_load(gear_load), .gear_in(gear_in), .gear(gear), .f_step(f_step),
        .sample_tick(sample_tick), .phase(phase), .wrap(wrap)
    );

    freq_gear_ctrl #(.N_GEARS(3), .DIV(2000), .STEP_TABLE(24'h05_03_01)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en_b), .gear_up(gear_up_b), .gear_dn(gear_dn_b),
        .gear_load(gear_load_b), .gear_in(gear_in_b), .gear(gear_b), .f_step(f_step_b),
        .sample_tick(sample_tick_b), .phase(phase_b), .wrap(wrap_b)
    );

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_gear = 0; m_step = tbl[0]; m_phase = 0; m_elapsed = 0;
        m_tick = 1'b0; m_wrap = 1'b0;
    endtask

    // One clock of the specification: a tick every TB_DIV enabled clocks,
    // phase += step mod 256, new step taken from the gear held before this edge.
    task automatic model_step();
        bit tk, cy;
        int sum, g_old;
        tk = 1'b0; cy = 1'b0;
        if (en) begin
            m_elapsed++;
            if (m_elapsed >= TB_DIV) begin tk = 1'b1; m_elapsed = 0; end
        end else begin
            m_elapsed = 0;
        end
        g_old = m_gear;
        if (gear_load) m_gear = (int'(gear_in) > 3) ? 3 : int'(gear_in);
        else if (gear_up && !gear_dn) m_gear = (m_gear + 1 > 3) ? 3 : m_gear + 1;
        else if (gear_dn && !gear_up) m_gear = (m_gear - 1 < 0) ? 0 : m_gear - 1;
        if (tk) begin
            sum = m_phase + m_step;
            cy = (sum >= 256);
            m_phase = sum % 256;
`ifdef FGC_WRAP_SYNC_EN
            if (cy) m_step = tbl[g_old];
`else
            m_step = tbl[g_old];
`endif
        end
        m_tick = tk; m_wrap = cy;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("gear", int'(gear), m_gear);
            check("f_step", int'(f_step), m_step);
            check("phase", int'(phase), m_phase);
            check("sample_tick", int'(sample_tick), int'(m_tick));
            check("wrap", int'(wrap), int'(m_wrap));
        end
    end

    task automatic gear_pulse(input bit u, input bit d, input bit l, input int gi);
        @(posedge clk); #1;
        gear_up = u; gear_dn = d; gear_load = l; gear_in = 2'(gi);
        @(posedge clk); #1;
        gear_up = 1'b0; gear_dn = 1'b0; gear_load = 1'b0;
    endtask

    task automatic b_pulse(input bit u, input bit d, input bit l, input int gi);
        @(posedge clk); #1;
        gear_up_b = u; gear_dn_b = d; gear_load_b = l; gear_in_b = 2'(gi);
        @(posedge clk); #1;
        gear_up_b = 1'b0; gear_dn_b = 1'b0; gear_load_b = 1'b0;
    endtask

    task automatic wait_ticks(input int n);
        int c;
        for (int i = 0; i < n; i++) begin
            c = 0;
            do begin @(posedge clk); #1; c++; end
            while (!sample_tick && c < 4 * TB_DIV);
            if (!sample_tick) begin
                check("tick_timeout", int'(sample_tick), 1);
                return;
            end
        end
    endtask

    task automatic count_to_tick(input string name, input int exp);
        int c;
        c = 0;
        do begin @(posedge clk); #1; c++; end
        while (!sample_tick && c < 4 * TB_DIV);
        check(name, c, exp);
    endtask

    initial begin
        int up_exp [5] = '{1, 2, 3, 3, 3};
        int dn_exp [5] = '{2, 1, 0, 0, 0};
        int n;

        rst_n = 1'b0; en = 1'b0; gear_up = 1'b0; gear_dn = 1'b0; gear_load = 1'b0;
        gear_in = 2'd0; en_b = 1'b0; gear_up_b = 1'b0; gear_dn_b = 1'b0;
        gear_load_b = 1'b0; gear_in_b = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_gear", int'(gear), 0);
        check("rst_f_step", int'(f_step), 1);
        check("rst_phase", int'(phase), 0);
        check("rst_tick", int'(sample_tick), 0);
        check("rst_wrap", int'(wrap), 0);
        check("rst_f_step_b", int'(f_step_b), 1);
        rst_n = 1'b1;
        chk_en = 1'b1;

        for (int i = 0; i < 5; i++) begin
            gear_pulse(1'b1, 1'b0, 1'b0, 0);
            check("gear_up_sat", int'(gear), up_exp[i]);
        end
        for (int i = 0; i < 5; i++) begin
            gear_pulse(1'b0, 1'b1, 1'b0, 0);
            check("gear_dn_sat", int'(gear), dn_exp[i]);
        end
        gear_pulse(1'b0, 1'b0, 1'b1, 1);
        check("load_1", int'(gear), 1);
        gear_pulse(1'b1, 1'b1, 1'b0, 0);
        check("up_dn_hold", int'(gear), 1);
        gear_pulse(1'b1, 1'b0, 1'b1, 2);
        check("load_wins", int'(gear), 2);

        b_pulse(1'b0, 1'b0, 1'b1, 3);
        check("clamp_n3", int'(gear_b), 2);
        b_pulse(1'b1, 1'b0, 1'b0, 0);
        check("sat_n3", int'(gear_b), 2);
        b_pulse(1'b0, 1'b1, 1'b0, 0);
        check("dn_n3", int'(gear_b), 1);

        en_b = 1'b1;
        n = 0;
        do begin @(posedge clk); #1; n++; end
        while (!sample_tick_b && n < 3000);
        check("first_tick_clk_2000", n, 2000);
        check("first_tick_phase", int'(phase_b), 1);
        en_b = 1'b0;

        @(posedge clk); #1; rst_n = 1'b0;
        @(posedge clk); #1; rst_n = 1'b1;
        en = 1'b1;
        wait_ticks(239);
        check("phase_239", int'(phase), 239);
        check("step1_no_early_wrap", int'(wrap), 0);
        gear_pulse(1'b0, 1'b0, 1'b1, 3);
        wait_ticks(1);
        check("phase_240", int'(phase), 240);
`ifdef FGC_WRAP_SYNC_EN
        check("step_held_until_wrap", int'(f_step), 1);
        wait_ticks(1);
        check("phase_241", int'(phase), 241);
        check("no_wrap_241", int'(wrap), 0);
        for (int k = 0; k < 20; k++) begin
            wait_ticks(1);
            if (wrap) break;
        end
        check("sync_wrap", int'(wrap), 1);
        check("sync_wrap_phase", int'(phase), 0);
        check("sync_commit_20", int'(f_step), 20);
`else
        check("step_commit_20", int'(f_step), 20);
        wait_ticks(1);
        check("phase_wrap_4", int'(phase), 4);
        check("wrap_on_tick", int'(wrap), 1);
        check("tick_with_wrap", int'(sample_tick), 1);
`endif

        repeat (TB_DIV * 3 / 4) @(posedge clk);
        #1; en = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("idle_no_tick", int'(sample_tick), 0);
        en = 1'b1;
        count_to_tick("reenable_tick_latency", TB_DIV);

        wait_ticks(3);
        repeat (5) @(posedge clk);
        #3; rst_n = 1'b0;
        #1;
        check("midrst_gear", int'(gear), 0);
        check("midrst_f_step", int'(f_step), 1);
        check("midrst_phase", int'(phase), 0);
        check("midrst_tick", int'(sample_tick), 0);
        check("midrst_wrap", int'(wrap), 0);
        @(posedge clk); #1; rst_n = 1'b1;
        count_to_tick("post_reset_tick_latency", TB_DIV);

        for (int i = 0; i < 8000; i++) begin
            int r;
            @(posedge clk); #1;
            en = ($urandom_range(19) != 0);
            r = $urandom_range(15);
            gear_up   = (r == 0) || (r == 3);
            gear_dn   = (r == 1) || (r == 3);
            gear_load = (r == 2);
            gear_in   = 2'($urandom_range(3));
        end
        @(posedge clk); #1;
        gear_up = 1'b0; gear_dn = 1'b0; gear_load = 1'b0; en = 1'b0;
        @(negedge clk);
        #1;
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
